// File: rtl/breath_pkg.sv
// Shared definitions for the PWM duty meter: FSM states and trend codes.
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } meas_state_t;

  localparam logic [1:0] TREND_EQ = 2'b00;
  localparam logic [1:0] TREND_UP = 2'b01;
  localparam logic [1:0] TREND_DN = 2'b10;

  // Without a valid previous measurement the trend is always "equal".
  function automatic logic [1:0] trend_code(input logic ref_ok,
                                            input logic up,
                                            input logic dn);
    if (!ref_ok) return TREND_EQ;
    if (up)      return TREND_UP;
    if (dn)      return TREND_DN;
    return TREND_EQ;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall detection.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      s_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of a PWM input, flags a
// stuck input and reports the brightness trend between consecutive periods.
module pwm_duty_meter
  import breath_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK_50MHz,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [1:0]       trend
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic s;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK_50MHz),
    .rst_n(reset_n),
    .d    (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  logic [CNT_W-1:0] edge_cnt;
  logic             any_edge;
  logic             timeout;

  assign any_edge = rise | fall;
  // An edge in the same cycle as the timeout always wins.
  assign timeout  = (edge_cnt == TIMEOUT_C) && !any_edge;

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
    end else if (any_edge) begin
      edge_cnt <= '0;
    end else if (edge_cnt != TIMEOUT_C) begin
      edge_cnt <= edge_cnt + ONE;
    end
  end

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             publish;
  logic             stuck_set;
  logic             stuck_clr;
  logic             ref_clr;
  logic             ref_valid;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    publish   = 1'b0;
    stuck_set = 1'b0;
    stuck_clr = 1'b0;
    ref_clr   = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      hi_d      = '0;
      per_d     = '0;
      stuck_clr = 1'b1;
      ref_clr   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          hi_d  = '0;
          per_d = '0;
          if (rise) begin
            state_d = HIGH;
            hi_d    = ONE;
            per_d   = ONE;
          end else if (timeout) begin
            state_d   = STUCK;
            stuck_set = 1'b1;
            ref_clr   = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            per_d   = per_q + ONE;
          end else if (timeout) begin
            state_d   = STUCK;
            stuck_set = 1'b1;
            ref_clr   = 1'b1;
            hi_d      = '0;
            per_d     = '0;
          end else begin
            hi_d  = hi_q + ONE;
            per_d = per_q + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            // Publish the finished period; the rise cycle opens the next one.
            publish = 1'b1;
            state_d = HIGH;
            hi_d    = ONE;
            per_d   = ONE;
          end else if (timeout) begin
            state_d   = STUCK;
            stuck_set = 1'b1;
            ref_clr   = 1'b1;
            hi_d      = '0;
            per_d     = '0;
          end else begin
            per_d = per_q + ONE;
          end
        end
        STUCK: begin
          hi_d  = '0;
          per_d = '0;
          if (rise) begin
            state_d   = HIGH;
            hi_d      = ONE;
            per_d     = ONE;
            stuck_clr = 1'b1;
          end else if (fall) begin
            state_d   = IDLE;
            stuck_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hi_d    = '0;
          per_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      per_q       <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
      trend       <= TREND_EQ;
      ref_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      per_q      <= per_d;
      meas_valid <= publish;

      if (publish) begin
        high_cnt   <= hi_q;
        period_cnt <= per_q;
        trend      <= trend_code(ref_valid, hi_q > high_cnt, hi_q < high_cnt);
        ref_valid  <= 1'b1;
      end else if (ref_clr) begin
        ref_valid <= 1'b0;
      end

      if (stuck_set) begin
        stuck       <= 1'b1;
        stuck_level <= s;
      end else if (stuck_clr) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized scoreboard bench for pwm_duty_meter with a segment-level model.
module tb_pwm_duty_meter;

  localparam int unsigned W  = 16;
  localparam int          TO = 200;
  localparam int          SS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          pwm_in;
  logic [W-1:0]  high_cnt;
  logic [W-1:0]  period_cnt;
  logic          meas_valid;
  logic          stuck;
  logic          stuck_level;
  logic [1:0]    trend;

  always #10 clk = ~clk;

  pwm_duty_meter #(
    .CNT_W      (W),
    .TIMEOUT    (TO),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK_50MHz  (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level),
    .trend      (trend)
  );

  typedef struct {
    int hi;
    int per;
    int tr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state, expressed in pin-level segments.
  logic level = 1'b0;
  int   run = 0;
  bit   enabled = 1'b1;
  bit   armed = 1'b0;
  bit   have_low = 1'b0;
  int   cur_hi = 0;
  int   cur_lo = 0;
  bit   ref_valid = 1'b0;
  int   prev_hi = 0;
  int   last_hi = 0;
  int   last_per = 0;
  bit   stuck_now = 1'b0;
  int   stuck_exp = 0;
  int   stuck_seen = 0;
  logic stuck_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_publish();
    exp_t e;
    e.hi  = cur_hi;
    e.per = cur_hi + cur_lo;
    if (!ref_valid)          e.tr = 0;
    else if (cur_hi > prev_hi) e.tr = 1;
    else if (cur_hi < prev_hi) e.tr = 2;
    else                     e.tr = 0;
    prev_hi   = cur_hi;
    ref_valid = 1'b1;
    last_hi   = e.hi;
    last_per  = e.per;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    run = 0; armed = 0; have_low = 0; cur_hi = 0; cur_lo = 0;
    ref_valid = 0; prev_hi = 0; last_hi = 0; last_per = 0; stuck_now = 0;
  endtask

  // Drive one constant-level segment of len cycles; optionally change enable at index en_at.
  task automatic seg(input logic lvl, input int len, input int en_at = -1, input logic en_val = 1'b1);
    int stuck_idx = -1;
    bit edge_now = (lvl != level);
    bit exit_chk = edge_now && stuck_now;
    if (edge_now) begin
      run   = 0;
      level = lvl;
      stuck_now = 0;
      if (enabled) begin
        if (lvl) begin
          if (armed && have_low) model_publish();
          armed = 1; have_low = 0; cur_hi = 0; cur_lo = 0;
        end else if (armed) begin
          have_low = 1;
        end
      end
    end
    for (int i = 0; i < len; i++) begin
      if (i == en_at) begin
        enable  = en_val;
        enabled = en_val;
        if (!en_val) begin
          armed = 0; have_low = 0; ref_valid = 0; stuck_now = 0;
        end
      end
      pwm_in = lvl;
      run++;
      if (enabled && armed) begin
        if (lvl) cur_hi++;
        else     cur_lo++;
      end
      if (enabled && run == TO + 2) begin
        armed = 0; have_low = 0; ref_valid = 0; stuck_now = 1;
        stuck_exp++;
        stuck_idx = i;
      end
      if (stuck_idx >= 0 && i == stuck_idx + 8) begin
        check("stuck_asserted", int'(stuck), 1);
        check("stuck_level", int'(stuck_level), int'(lvl));
        check("stuck_hold_high_cnt", int'(high_cnt), last_hi);
        check("stuck_hold_period_cnt", int'(period_cnt), last_per);
      end
      if (exit_chk && i == 8) check("stuck_cleared", int'(stuck), 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input int hi, input int per);
    seg(1'b1, hi);
    seg(1'b0, per - hi);
  endtask

  // Monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      stuck_prev = 1'b0;
    end else begin
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("high_cnt", int'(high_cnt), e.hi);
          check("period_cnt", int'(period_cnt), e.per);
          check("trend", int'(trend), e.tr);
        end
      end
      if (stuck && !stuck_prev) stuck_seen++;
      stuck_prev = stuck;
    end
  end

  initial begin : watchdog
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_high_cnt"}, int'(high_cnt), 0);
    check({tag, "_period_cnt"}, int'(period_cnt), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
    check({tag, "_stuck_level"}, int'(stuck_level), 0);
    check({tag, "_trend"}, int'(trend), 0);
  endtask

  initial begin : stim
    int hi, lo, r;
    reset_n = 1'b0;
    enable  = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    model_reset();
    seg(1'b0, 20);

    // Steady 30/100, then rising and falling brightness.
    period(30, 100); period(30, 100); period(30, 100);
    period(40, 100); period(35, 100); period(35, 100);

    // Input stuck high, then fall and restart.
    seg(1'b1, TO + 40);
    seg(1'b0, 50);
    period(30, 100); period(30, 100); period(45, 100);

    // Enable dropped mid-HIGH for ~500 cycles, raised mid-LOW.
    seg(1'b1, 60, 20, 1'b0);
    seg(1'b0, 40);
    repeat (4) period(30, 100);
    seg(1'b1, 30);
    seg(1'b0, 70, 20, 1'b1);
    period(25, 100); period(25, 100); period(50, 100);

    // Rise lands on the cycle the timeout would fire: edge wins.
    seg(1'b1, 30);
    seg(1'b0, TO + 1);
    period(30, 80); period(30, 80);

    // Randomized high/low times, occasionally long enough to go stuck.
    for (int n = 0; n < 40; n++) begin
      hi = $urandom_range(1, 120);
      r  = $urandom_range(0, 9);
      lo = (r == 0) ? $urandom_range(TO + 2, TO + 30) : $urandom_range(1, 120);
      seg(1'b1, hi);
      seg(1'b0, lo);
    end
    period(1, 3); period(1, 2); period(2, 3);

    // Asynchronous reset mid-LOW.
    seg(1'b1, 30);
    seg(1'b0, 40);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seg(1'b0, 40);
    period(30, 100); period(30, 100); period(20, 100);
    seg(1'b1, 10);

    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("stuck_events", stuck_seen, stuck_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
